proc_exec_core: RTL and testbench

Parametrised successor to the fixed 16-bit `Processor`: a multi-cycle execute core with an 8-entry register file, decoding the same 16-bit RRR/RRI instruction word. It generalises the data width and immediate handling, and adds a valid/ready instruction handshake and a result-valid strobe. It also adds ALU flags, a multi-cycle multiply and a serial register-initialisation port, which replaces the `init_values` array port. It sits between the instruction source (testbench or future fetch unit) and result consumers.

---
 rtl/proc_pkg.sv | 36 +++
 rtl/proc_exec_core_seq_multiplier.sv | 60 ++++++
 rtl/proc_exec_core.sv | 179 +++++++++++++++++
 tb/tb_proc_exec_core.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// proc_pkg
// Shared definitions for the execute core: opcode encodings, instruction
// field positions and the control FSM state type.
package proc_pkg;

    // Opcodes, instruction[15:13]
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_ADDI = 3'b001;
    localparam logic [2:0] OP_SUBI = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_LI   = 3'b111;

    // Instruction word layout: {op, rA, rB, low7}
    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 13;
    localparam int RA_MSB  = 12;
    localparam int RA_LSB  = 10;
    localparam int RB_MSB  = 9;
    localparam int RB_LSB  = 7;
    localparam int RC_MSB  = 2;
    localparam int RC_LSB  = 0;
    localparam int IMM_MSB = 6;
    localparam int IMM_LSB = 0;
    localparam int LI_MSB  = 9;
    localparam int LI_LSB  = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2
    } state_t;

endpackage

// File: rtl/proc_exec_core_seq_multiplier.sv
// seq_multiplier
// Unsigned shift-add multiplier, one multiplier bit per cycle.
// Ports:
//   clk, reset : clock, synchronous active-high reset (aborts a run)
//   start      : load a/b on this edge and begin a W-cycle run
//   a, b       : operands (multiplicand, multiplier)
//   done       : one-cycle pulse, high the cycle after the last step
//   product    : full 2*W-bit product, valid while done is high
module seq_multiplier #(
    parameter int W = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           done,
    output logic [2*W-1:0] product
);

    localparam int CW = $clog2(W + 1);

    logic [2*W-1:0] mcand;
    logic [W-1:0]   mplier;
    logic [CW-1:0]  count;
    logic           running;

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand   <= '0;
            mplier  <= '0;
            count   <= '0;
            running <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            done <= 1'b0;
            if (start && !running) begin
                mcand   <= {{W{1'b0}}, a};
                mplier  <= b;
                product <= '0;
                count   <= CW'(W);
                running <= 1'b1;
            end else if (running) begin
                if (mplier[0]) begin
                    product <= product + mcand;
                end
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                count  <= count - 1'b1;
                // Final step: product settles on this edge, done follows it.
                if (count == CW'(1)) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/proc_exec_core.sv
// proc_exec_core
// Multi-cycle execute core with an 8-entry register file. Decodes the 16-bit
// RRR/RRI instruction word, runs single-cycle ALU ops in EXEC and MUL through
// a sequential shift-add multiplier.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   init_we/addr/data     : serial register initialisation (IDLE only)
//   instr_valid/ready     : instruction handshake
//   instruction           : {op, rA, rB, low7}
//   result_valid          : one-cycle strobe, rA written on this cycle
//   result, flag_z/flag_c : last writeback value and its flags (held)
//   busy                  : core is not IDLE
//   dbg_addr/dbg_data     : combinational register-file read
//   dbg_state             : current FSM state
//
// Handshake: an instruction transfers on a rising edge where instr_valid and
// instr_ready are both high. instr_ready does not depend on instr_valid; the
// source holds instr_valid and instruction stable until the transfer.
module proc_exec_core
    import proc_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int IMM_SIGNED = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init_we,
    input  logic [2:0]        init_addr,
    input  logic [DATA_W-1:0] init_data,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       instruction,
    output logic              result_valid,
    output logic [DATA_W-1:0] result,
    output logic              flag_z,
    output logic              flag_c,
    output logic              busy,
    input  logic [2:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output state_t            dbg_state
);

    state_t            state;
    logic [DATA_W-1:0] regs [8];

    // Latched at accept
    logic [2:0]        op_q;
    logic [2:0]        ra_q;
    logic [DATA_W-1:0] opb_q;
    logic [DATA_W-1:0] opc_q;

    // Decode of the offered instruction
    logic [2:0]        dec_op, dec_ra, dec_rb, dec_rc;
    logic [DATA_W-1:0] imm_val, li_val, dec_opc;
    logic              accept;

    assign dec_op = instruction[OP_MSB:OP_LSB];
    assign dec_ra = instruction[RA_MSB:RA_LSB];
    assign dec_rb = instruction[RB_MSB:RB_LSB];
    assign dec_rc = instruction[RC_MSB:RC_LSB];

    always_comb begin
        imm_val = {{(DATA_W-7){1'b0}}, instruction[IMM_MSB:IMM_LSB]};
        if (IMM_SIGNED != 0) begin
            imm_val = {{(DATA_W-7){instruction[IMM_MSB]}}, instruction[IMM_MSB:IMM_LSB]};
        end
        li_val = DATA_W'(instruction[LI_MSB:LI_LSB]);
        // Second operand: register, immediate or load value depending on op
        case (dec_op)
            OP_ADDI, OP_SUBI: dec_opc = imm_val;
            OP_LI:            dec_opc = li_val;
            default:          dec_opc = regs[dec_rc];
        endcase
    end

    assign instr_ready = (state == IDLE) && !init_we && !reset;
    assign accept      = instr_valid && instr_ready;
    assign busy        = (state != IDLE);
    assign dbg_data    = regs[dbg_addr];
    assign dbg_state   = state;

    // ALU on latched operands
    logic [DATA_W:0]   add_wide;
    logic [DATA_W-1:0] alu_res;
    logic              alu_c;

    always_comb begin
        add_wide = '0;
        alu_res  = '0;
        alu_c    = 1'b0;
        case (op_q)
            OP_ADD, OP_ADDI: begin
                add_wide = {1'b0, opb_q} + {1'b0, opc_q};
                alu_res  = add_wide[DATA_W-1:0];
                alu_c    = add_wide[DATA_W];
            end
            OP_SUB, OP_SUBI: begin
                alu_res = opb_q - opc_q;
                alu_c   = (opb_q < opc_q);
            end
            OP_AND:  alu_res = opb_q & opc_q;
            OP_OR:   alu_res = opb_q | opc_q;
            OP_LI:   alu_res = opc_q;
            default: alu_res = '0;
        endcase
    end

    // Multiplier takes operands straight from the register file on accept,
    // the same edge the core latches them.
    logic                  mul_start;
    logic                  mul_done;
    logic [2*DATA_W-1:0]   mul_product;

    assign mul_start = accept && (dec_op == OP_MUL);

    seq_multiplier #(
        .W(DATA_W)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (regs[dec_rb]),
        .b       (regs[dec_rc]),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
            op_q         <= OP_ADD;
            ra_q         <= '0;
            opb_q        <= '0;
            opc_q        <= '0;
            result       <= '0;
            flag_z       <= 1'b0;
            flag_c       <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (init_we) begin
                        regs[init_addr] <= init_data;
                    end else if (accept) begin
                        op_q  <= dec_op;
                        ra_q  <= dec_ra;
                        opb_q <= regs[dec_rb];
                        opc_q <= dec_opc;
                        state <= (dec_op == OP_MUL) ? MUL : EXEC;
                    end
                end
                EXEC: begin
                    regs[ra_q]   <= alu_res;
                    result       <= alu_res;
                    flag_z       <= (alu_res == '0);
                    flag_c       <= alu_c;
                    result_valid <= 1'b1;
                    state        <= IDLE;
                end
                MUL: begin
                    if (mul_done) begin
                        regs[ra_q]   <= mul_product[DATA_W-1:0];
                        result       <= mul_product[DATA_W-1:0];
                        flag_z       <= (mul_product[DATA_W-1:0] == '0);
                        flag_c       <= |mul_product[2*DATA_W-1:DATA_W];
                        result_valid <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_proc_exec_core.sv
// tb_proc_exec_core
// Directed test of proc_exec_core at DATA_W=16. A second instance with
// IMM_SIGNED=1 shares all inputs and is checked for the signed-immediate case.
module tb_proc_exec_core;
    import proc_pkg::*;

    localparam int W = 16;

    // Clock / reset
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Shared stimulus
    logic         init_we;
    logic [2:0]   init_addr;
    logic [W-1:0] init_data;
    logic         instr_valid;
    logic [15:0]  instruction;
    logic [2:0]   dbg_addr;

    // Unsigned-immediate instance outputs
    logic         instr_ready, result_valid, flag_z, flag_c, busy;
    logic [W-1:0] result, dbg_data;
    state_t       dbg_state;

    // Signed-immediate instance outputs
    logic         s_instr_ready, s_result_valid, s_flag_z, s_flag_c, s_busy;
    logic [W-1:0] s_result, s_dbg_data;
    state_t       s_dbg_state;

    proc_exec_core #(.DATA_W(W), .IMM_SIGNED(0)) u_dut (
        .clk(clk), .reset(reset),
        .init_we(init_we), .init_addr(init_addr), .init_data(init_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instruction(instruction),
        .result_valid(result_valid), .result(result),
        .flag_z(flag_z), .flag_c(flag_c), .busy(busy),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_state(dbg_state)
    );

    proc_exec_core #(.DATA_W(W), .IMM_SIGNED(1)) u_dut_s (
        .clk(clk), .reset(reset),
        .init_we(init_we), .init_addr(init_addr), .init_data(init_data),
        .instr_valid(instr_valid), .instr_ready(s_instr_ready), .instruction(instruction),
        .result_valid(s_result_valid), .result(s_result),
        .flag_z(s_flag_z), .flag_c(s_flag_c), .busy(s_busy),
        .dbg_addr(dbg_addr), .dbg_data(s_dbg_data), .dbg_state(s_dbg_state)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] enc(input logic [2:0] op, input logic [2:0] ra,
                                        input logic [2:0] rb, input logic [6:0] low7);
        return {op, ra, rb, low7};
    endfunction

    // Driver tasks; all run from #1 after a rising edge
    task automatic init_reg(input logic [2:0] a, input logic [W-1:0] d);
        init_we   = 1'b1;
        init_addr = a;
        init_data = d;
        @(posedge clk); #1;
        init_we   = 1'b0;
    endtask

    // Returns at #1 after the accepting edge
    task automatic issue(input logic [15:0] instr);
        int n;
        n = 0;
        instr_valid = 1'b1;
        instruction = instr;
        #1;
        while (!instr_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("accept_timeout", (n < 100), 1);
        @(posedge clk); #1;
        instr_valid = 1'b0;
    endtask

    // Edges from accept until result_valid is seen
    task automatic wait_result(output int lat);
        lat = 0;
        while (!result_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic read_reg(input logic [2:0] a, output logic [W-1:0] d);
        dbg_addr = a;
        #1;
        d = dbg_data;
    endtask

    initial begin
        int           lat;
        int           low;
        logic         rv_seen;
        logic [W-1:0] rd;

        reset       = 1'b1;
        init_we     = 1'b0;
        init_addr   = '0;
        init_data   = '0;
        instr_valid = 1'b0;
        instruction = '0;
        dbg_addr    = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready",  instr_ready,  0);
        check("rst_rv",     result_valid, 0);
        check("rst_busy",   busy,         0);
        check("rst_result", result,       0);
        check("rst_z",      flag_z,       0);
        check("rst_c",      flag_c,       0);
        reset = 1'b0;
        #1;
        check("ready_after_rst", instr_ready, 1);

        init_reg(3'd0, 16'd10);
        init_reg(3'd1, 16'd20);
        init_reg(3'd2, 16'd30);

        // ADD r0 = r1 + r2
        issue(enc(OP_ADD, 3'd0, 3'd1, 7'd2));
        check("add_rv_early", result_valid, 0);
        wait_result(lat);
        check("add_lat",    lat,    1);
        check("add_result", result, 50);
        check("add_z",      flag_z, 0);
        check("add_c",      flag_c, 0);
        read_reg(3'd0, rd);
        check("add_r0", rd, 50);
        @(posedge clk); #1;
        check("rv_one_cycle", result_valid, 0);

        // ADDI r0 = r1 + 1
        issue(enc(OP_ADDI, 3'd0, 3'd1, 7'd1));
        wait_result(lat);
        check("addi_result", result, 21);
        check("addi_c",      flag_c, 0);

        // SUBI r0 = r1 - 1
        issue(enc(OP_SUBI, 3'd0, 3'd1, 7'd1));
        wait_result(lat);
        check("subi_result", result, 19);
        check("subi_c",      flag_c, 0);

        // SUB r0 = r1 - r2 (borrow)
        issue(enc(OP_SUB, 3'd0, 3'd1, 7'd2));
        wait_result(lat);
        check("sub_result", result, 16'hFFF6);
        check("sub_c",      flag_c, 1);
        check("sub_z",      flag_z, 0);

        // MUL r3 = r1 * r2 with an ADD r6 = r1 + r2 held behind it
        issue(enc(OP_MUL, 3'd3, 3'd1, 7'd2));
        instr_valid = 1'b1;
        instruction = enc(OP_ADD, 3'd6, 3'd1, 7'd2);
        lat = 0;
        low = 0;
        while (!result_valid && lat < 100) begin
            if (!instr_ready) low++;
            @(posedge clk); #1;
            lat++;
        end
        check("mul_lat",       lat,    17);
        check("mul_ready_low", low,    17);
        check("mul_result",    result, 600);
        check("mul_c",         flag_c, 0);
        check("mul_z",         flag_z, 0);
        read_reg(3'd3, rd);
        check("mul_r3", rd, 600);
        @(posedge clk); #1;
        instr_valid = 1'b0;
        wait_result(lat);
        check("held_add_lat",    lat,    1);
        check("held_add_result", result, 50);
        read_reg(3'd6, rd);
        check("held_add_r6", rd, 50);

        // MUL overflow: 0x0100 * 0x0100 = 0x10000
        init_reg(3'd4, 16'h0100);
        issue(enc(OP_MUL, 3'd5, 3'd4, 7'd4));
        wait_result(lat);
        check("mulovf_result", result, 0);
        check("mulovf_z",      flag_z, 1);
        check("mulovf_c",      flag_c, 1);

        // ADDI carry out: 0xFFFF + 1
        init_reg(3'd4, 16'hFFFF);
        issue(enc(OP_ADDI, 3'd5, 3'd4, 7'd1));
        wait_result(lat);
        check("addicarry_result", result, 0);
        check("addicarry_z",      flag_z, 1);
        check("addicarry_c",      flag_c, 1);

        // SUBI r0 = r1 - 0x7F: zero-extended 127 vs sign-extended -1
        issue(enc(OP_SUBI, 3'd0, 3'd1, 7'h7F));
        wait_result(lat);
        check("subi_u_result", result,   16'hFF95);
        check("subi_u_c",      flag_c,   1);
        check("subi_s_result", s_result, 21);
        check("subi_s_rv",     s_result_valid, 1);

        // Init and instruction offered together: init wins, ADDI r7 = r1 + 5
        init_we     = 1'b1;
        init_addr   = 3'd1;
        init_data   = 16'd100;
        instr_valid = 1'b1;
        instruction = enc(OP_ADDI, 3'd7, 3'd1, 7'd5);
        #1;
        check("init_blocks_ready", instr_ready, 0);
        @(posedge clk); #1;
        init_we = 1'b0;
        #1;
        check("ready_after_init", instr_ready, 1);
        read_reg(3'd1, rd);
        check("init_r1", rd, 100);
        @(posedge clk); #1;
        instr_valid = 1'b0;
        wait_result(lat);
        check("init_then_addi_lat",    lat,    1);
        check("init_then_addi_result", result, 105);

        // Reset in cycle 5 of a MUL
        issue(enc(OP_MUL, 3'd3, 3'd1, 7'd2));
        rv_seen = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            rv_seen = rv_seen | result_valid;
        end
        reset = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            rv_seen = rv_seen | result_valid;
        end
        check("midrst_ready_in_rst", instr_ready, 0);
        check("midrst_busy",         busy,        0);
        reset = 1'b0;
        #1;
        check("midrst_ready_after", instr_ready, 1);
        repeat (20) begin
            @(posedge clk); #1;
            rv_seen = rv_seen | result_valid;
        end
        check("midrst_no_rv",  rv_seen, 0);
        check("midrst_result", result,  0);
        for (int i = 0; i < 8; i++) begin
            read_reg(3'(i), rd);
            check($sformatf("midrst_r%0d", i), rd, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
